// File: rtl/stable_arb_pkg.sv
// stable_arb_pkg: shared state type and default sizing for the stable bus arbiter.
package stable_arb_pkg;
  typedef enum logic {IDLE, DRIVE} arb_state_e;
  localparam int DEF_N       = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/stable_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search from i_ptr upward, wrapping at N-1.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_any,
  output logic [$clog2(N)-1:0] o_win
);
  localparam int W = $clog2(N);
  always_comb begin
    o_any = 1'b0;
    o_win = '0;
    // Walk offsets from far to near so the nearest requester is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_any = 1'b1;
        o_win = W'((int'(i_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/stable_bus_arbiter_sva.sv
// stable_bus_arbiter_sva: bus stability and grant one-hot properties, bound into the arbiter.
module stable_bus_arbiter_sva #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 bus_valid,
  input logic                 bus_ready,
  input logic [DW-1:0]        bus_data,
  input logic [$clog2(N)-1:0] bus_owner,
  input logic [N-1:0]         gnt
);
  a_stable: assert property (@(posedge clk) disable iff (rst)
    bus_valid && !bus_ready |=> $stable(bus_data) && $stable(bus_owner) && bus_valid);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
endmodule

bind stable_bus_arbiter stable_bus_arbiter_sva #(.N(N), .DW(DW)) u_sva (
  .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(bus_ready),
  .bus_data(bus_data), .bus_owner(bus_owner), .gnt(gnt)
);

// File: rtl/stable_bus_arbiter.sv
// stable_bus_arbiter: round-robin N:1 valid/ready arbiter that holds bus payload stable
// while stalled and raises a sticky error after TIMEOUT stall cycles.
module stable_bus_arbiter
  import stable_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         gnt,
  output logic                 bus_valid,
  output logic [DW-1:0]        bus_data,
  output logic [$clog2(N)-1:0] bus_owner,
  input  logic                 bus_ready,
  output logic                 stall_err
);
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  arb_state_e     r_state;
  logic [W-1:0]   r_ptr, r_owner, w_win;
  logic [N-1:0]   r_gnt;
  logic [DW-1:0]  r_data;
  logic [CW-1:0]  r_cnt;
  logic           r_valid, r_err, w_any, w_slot;
  rr_picker #(.N(N)) u_pick (.i_req(req), .i_ptr(r_ptr), .o_any(w_any), .o_win(w_win));
  assign w_slot    = (r_state == IDLE) || bus_ready;
  assign gnt       = r_gnt;
  assign bus_valid = r_valid;
  assign bus_data  = r_data;
  assign bus_owner = r_owner;
  assign stall_err = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (w_slot && w_any) begin
        r_state <= DRIVE;
        r_valid <= 1'b1;
        r_data  <= req_data[w_win*DW +: DW];
        r_owner <= w_win;
        r_gnt   <= N'(1) << w_win;
        r_ptr   <= (w_win == W'(N - 1)) ? '0 : w_win + 1'b1;
      end else if (w_slot) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
      end
      // Stall counting never touches bus_valid: the held transfer always wins.
      if (r_valid && !bus_ready) begin
        if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
        if (TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1)) r_err <= 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_stable_bus_arbiter.sv
// tb_stable_bus_arbiter: scenario tasks with a transfer scoreboard for stable_bus_arbiter.
module tb_stable_bus_arbiter;
  localparam int N = 4, DW = 8, TIMEOUT = 16;
  logic            clk = 1'b0, rst = 1'b1, bus_ready = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            bus_valid, stall_err;
  logic [DW-1:0]   bus_data;
  logic [1:0]      bus_owner;
  logic [9:0]      sb_q[$];
  logic [9:0]      sb_exp;
  int n_cmp = 0, n_bad = 0;

  stable_bus_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_owner(bus_owner),
    .bus_ready(bus_ready), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus_valid && bus_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL xfer_unexpected: got owner=%0d data=%h, required no transfer", bus_owner, bus_data);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({bus_owner, bus_data} !== sb_exp) begin
          n_bad++;
          $display("FAIL xfer: got owner=%0d data=%h, required owner=%0d data=%h",
                   bus_owner, bus_data, sb_exp[9:8], sb_exp[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    bus_ready = 1'b1;
    step();
    n_cmp++;
    if ({gnt, bus_valid, bus_data, bus_owner, stall_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got gnt=%b v=%b d=%h o=%0d err=%b, required all 0",
               gnt, bus_valid, bus_data, bus_owner, stall_err);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({gnt, bus_valid, stall_err} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got gnt=%b v=%b err=%b, required 0", gnt, bus_valid, stall_err);
    end
  endtask

  task automatic test_single();
    set_data(0, 8'hA5);
    req = 4'b0001;
    bus_ready = 1'b1;
    sb_q.push_back({2'd0, 8'hA5});
    step();
    req = '0;
    n_cmp++;
    if (gnt !== 4'b0001 || bus_valid !== 1'b1 || bus_data !== 8'hA5 || bus_owner !== 2'd0) begin
      n_bad++;
      $display("FAIL single_grant: got gnt=%b v=%b d=%h o=%0d, required 0001 1 a5 0",
               gnt, bus_valid, bus_data, bus_owner);
    end
    step();
    n_cmp++;
    if (bus_valid !== 1'b0 || gnt !== '0) begin
      n_bad++;
      $display("FAIL single_done: got v=%b gnt=%b, required 0 0000", bus_valid, gnt);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
    req = 4'b1111;
    bus_ready = 1'b1;
    for (int k = 0; k < 5; k++) sb_q.push_back({2'(k % 4), 8'(8'h10 + k % 4)});
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 4) req = '0;
      n_cmp++;
      if (gnt !== (4'b0001 << (k % 4)) || bus_valid !== 1'b1 || bus_owner !== 2'(k % 4) ||
          bus_data !== 8'(8'h10 + k % 4)) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got gnt=%b v=%b o=%0d d=%h, required owner %0d valid",
                 k, gnt, bus_valid, bus_owner, bus_data, k % 4);
      end
    end
    step();
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got v=%b, required 0", bus_valid);
    end
  endtask

  task automatic test_hold_stable();
    apply_reset();
    set_data(2, 8'h3C);
    bus_ready = 1'b0;
    req = 4'b0100;
    sb_q.push_back({2'd2, 8'h3C});
    step();
    req = '0;
    n_cmp++;
    if (gnt !== 4'b0100 || bus_owner !== 2'd2 || bus_data !== 8'h3C) begin
      n_bad++;
      $display("FAIL hold_grant: got gnt=%b o=%0d d=%h, required 0100 2 3c", gnt, bus_owner, bus_data);
    end
    for (int c = 0; c < 5; c++) begin
      set_data(2, (c % 2 == 0) ? 8'hC3 : 8'h00);
      step();
      n_cmp++;
      if (bus_valid !== 1'b1 || bus_data !== 8'h3C || bus_owner !== 2'd2 || stall_err !== 1'b0) begin
        n_bad++;
        $display("FAIL hold[%0d]: got v=%b d=%h o=%0d err=%b, required 1 3c 2 0",
                 c, bus_valid, bus_data, bus_owner, stall_err);
      end
    end
    bus_ready = 1'b1;
    step();
    n_cmp++;
    if (bus_valid !== 1'b0 || stall_err !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_done: got v=%b err=%b, required 0 0", bus_valid, stall_err);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    set_data(0, 8'h77);
    bus_ready = 1'b0;
    req = 4'b0001;
    sb_q.push_back({2'd0, 8'h77});
    step();
    req = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_cmp++;
      if (bus_valid !== 1'b1 || bus_data !== 8'h77 || stall_err !== (k >= TIMEOUT)) begin
        n_bad++;
        $display("FAIL timeout[%0d]: got v=%b d=%h err=%b, required 1 77 %b",
                 k, bus_valid, bus_data, stall_err, k >= TIMEOUT);
      end
    end
    apply_reset();
    n_cmp++;
    if (stall_err !== 1'b0 || bus_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: got err=%b v=%b, required 0 0", stall_err, bus_valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h50 + i));
    bus_ready = 1'b0;
    req = 4'b0100;
    sb_q.push_back({2'd2, 8'h52});
    step();
    req = '0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, bus_valid, bus_data, bus_owner, stall_err} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got gnt=%b v=%b d=%h o=%0d err=%b, required all 0",
               gnt, bus_valid, bus_data, bus_owner, stall_err);
    end
    step();
    rst = 1'b0;
    sb_q.delete();
    bus_ready = 1'b1;
    req = 4'b1010;
    sb_q.push_back({2'd1, 8'h51});
    step();
    req = '0;
    n_cmp++;
    if (gnt !== 4'b0010 || bus_owner !== 2'd1 || bus_data !== 8'h51) begin
      n_bad++;
      $display("FAIL post_reset_grant: got gnt=%b o=%0d d=%h, required 0010 1 51", gnt, bus_owner, bus_data);
    end
    step();
  endtask

  task automatic test_rr_ptr();
    apply_reset();
    for (int i = 0; i < N; i++) set_data(i, 8'(8'hE0 + i));
    bus_ready = 1'b1;
    req = 4'b0010;
    sb_q.push_back({2'd1, 8'hE1});
    step();
    req = '0;
    n_cmp++;
    if (gnt !== 4'b0010 || bus_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rr_single: got gnt=%b v=%b, required 0010 1", gnt, bus_valid);
    end
    step();
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_idle: got v=%b, required 0", bus_valid);
    end
    req = 4'b1111;
    sb_q.push_back({2'd2, 8'hE2});
    step();
    req = '0;
    n_cmp++;
    if (gnt !== 4'b0100 || bus_owner !== 2'd2) begin
      n_bad++;
      $display("FAIL rr_ptr_next: got gnt=%b o=%0d, required 0100 2", gnt, bus_owner);
    end
    step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stable();
    test_timeout();
    test_async_reset();
    test_rr_ptr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
